rwsgen_arb: RTL and testbench
=============================

# rwsgen_arb

Multi-channel read/write strobe generator and arbiter between NCH Avalon-style requesters and one shared microprocessor register bus. Each request becomes one single-cycle upws or uprs strobe with level enables. Completion on uprdy or a programmable timeout is returned as a one-cycle waitrequest release. readdata and a per-channel readdatavalid return the read result. Sits between the bus-interface layer and the register-file decode.

## Interface
- NCH, 2: number of requester channels (1..8)
- AW, 16: address width
- DW, 32: data width
- TOW, 8: timeout counter width
- TOMAX, 255: cycles (after the first) waited for uprdy before timeout; must be < 2^TOW
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- write  in  NCH  per-channel write request, level, held until its waitrequest is low
- read  in  NCH  per-channel read request, level, held until its waitrequest is low
- address  in  NCH*AW  channel i at [i*AW +: AW]
- writedata  in  NCH*DW  channel i at [i*DW +: DW]
- waitrequest  out  NCH  low for exactly one cycle when the channel's transaction completes
- readdata  out  DW  read result, registered, held until the next completion
- readdatavalid  out  NCH  one-cycle pulse with completion of a read
- timeout  out  NCH  one-cycle pulse with a completion caused by timeout
- upa  out  AW  registered address to register bus
- updo  out  DW  registered write data
- updi  in  DW  read data from register bus, sampled with uprdy
- uprdy  in  1  register-bus completion, one cycle
- upws / uprs  out  1  one-cycle write/read strobes
- upen_ws / upen_rs  out  1  level enables, high from the strobe cycle through the cycle uprdy/timeout is seen

## Operation
- FSM states: IDLE, STRB, WAIT, DONE.
- IDLE:
  - If any channel has read|write, grant by round-robin, searching from last_grant+1 mod NCH.
  - Latch grant, type, upa and updo, then go to STRB.
  - With no request, stay in IDLE.
- STRB:
  - Assert upws (write) or uprs (read) and the matching upen.
  - Timeout counter = 0.
  - If uprdy, go to DONE; else go to WAIT.
- WAIT:
  - upen held high.
  - If uprdy, go to DONE.
  - Else if counter == TOMAX, set the timeout flag and go to DONE.
  - Else counter+1.
- Read data capture:
  - On a read completed by uprdy, readdata <= updi.
  - On a read completed by timeout, readdata <= all-ones.
  - Writes leave readdata unchanged.
- DONE:
  - waitrequest[grant] = 0.
  - readdatavalid[grant] = 1 if read; timeout[grant] = 1 if timed out.
  - last_grant <= grant, then go to IDLE.
- uprdy is ignored in IDLE and DONE.
- read and write both high on the same channel: write only; the single completion acknowledges both.
- A requester must drop or change its request in the cycle after its waitrequest is low. Requests still present are re-arbitrated as new transactions.
- Reset:
  - state IDLE, last_grant = NCH-1 (channel 0 first), counter 0.
  - upa, updo and readdata are 0.
  - All strobes, enables, readdatavalid and timeout are 0; waitrequest is all ones.
- Reset mid-transaction aborts it with no completion pulse. The requester still sees waitrequest high and keeps requesting, so the request is serviced afresh after reset.

## Timing
- Request seen in IDLE at cycle 0 -> strobe at cycle 1 -> earliest completion (uprdy in cycle 1) is waitrequest low at cycle 2.
- uprdy in cycle k (k≥1) -> DONE at cycle k+1.
- Timeout, with no uprdy: counter reaches TOMAX at cycle TOMAX+1 -> DONE at cycle TOMAX+2.
- Per-transaction throughput: at least 3 cycles (IDLE, STRB, DONE). Back-to-back transactions never overlap strobes.
- waitrequest, readdatavalid and timeout are decoded from registered state/grant only; no combinational input-to-output path.
- upws and uprs are never high in the same cycle. Each transaction produces exactly one strobe.

## Structure
- Shared package rwsgen_pkg: FSM state encoding localparams (IDLE=0, STRB=1, WAIT=2, DONE=3) and the default TOMAX.
- Sub-module rr_arb #(NCH):
  - combinational round-robin grant from req[NCH-1:0] and last_grant;
  - outputs gnt_idx and gnt_vld.
- Datapath muxes, FSM and counter live in rwsgen_arb.

## Test plan
- Single write, ch0 addr 0x0010 data 0xA5A5_5A5A, uprdy 3 cycles after the strobe:
  - upws high only in cycle 1, with upa=0x0010 and updo=0xA5A5_5A5A;
  - upen_ws high cycles 1–4;
  - waitrequest[0] low only in cycle 5.
- Read ch1 with uprdy in the strobe cycle and updi=0x1234_5678:
  - uprs at cycle 1;
  - readdata=0x1234_5678, readdatavalid[1] and waitrequest[1] low at cycle 2.
- ch0 and ch1 both requesting continuously (write ch0, read ch1), immediate uprdy:
  - grants alternate 0,1,0,1;
  - one strobe every 3 cycles, no overlap.
- TOMAX=15, read ch0, uprdy never asserted:
  - timeout[0] and readdatavalid[0] at cycle 17;
  - readdata=0xFFFF_FFFF.
- rst asserted during WAIT:
  - next cycle all outputs at reset values, no completion pulses;
  - after release, the still-held request gets a fresh strobe 1 cycle later.
- read[0] and write[0] both high:
  - only upws is issued, no uprs;
  - one waitrequest[0] low, readdatavalid[0] stays 0.

Source files
------------

// File: rtl/rwsgen_pkg.sv
// rtl/rwsgen_pkg.sv - shared types and constants for the strobe generator/arbiter
// Contents:
//   IDLE_ENC..DONE_ENC : FSM state encodings
//   state_e            : FSM state type built on those encodings
//   TOMAX_DEFAULT      : default uprdy wait limit in cycles
//   idx_w()            : width of a channel index (at least 1 bit)
package rwsgen_pkg;

  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] STRB_ENC = 2'd1;
  localparam logic [1:0] WAIT_ENC = 2'd2;
  localparam logic [1:0] DONE_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE_ENC,
    ST_STRB = STRB_ENC,
    ST_WAIT = WAIT_ENC,
    ST_DONE = DONE_ENC
  } state_e;

  localparam int TOMAX_DEFAULT = 255;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rwsgen_arb_rr.sv
// rtl/rwsgen_arb_rr.sv - combinational round-robin grant for the requester channels
// Module rr_arb
// Ports:
//   req_i        : per-channel request (read | write)
//   last_grant_i : channel granted most recently
//   gnt_idx_o    : granted channel, first requester after last_grant_i
//   gnt_vld_o    : at least one channel is requesting
module rr_arb #(
  parameter int NCH = 2,
  parameter int IW  = 1
) (
  input  logic [NCH-1:0] req_i,
  input  logic [IW-1:0]  last_grant_i,
  output logic [IW-1:0]  gnt_idx_o,
  output logic           gnt_vld_o
);

  int cand;

  // Walk offsets from farthest to nearest so the nearest requester after
  // last_grant_i is the final (winning) assignment.
  always_comb begin
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    cand      = 0;
    for (int k = NCH; k >= 1; k--) begin
      cand = (int'(last_grant_i) + k) % NCH;
      if (|(req_i & (NCH'(1) << cand))) begin
        gnt_idx_o = IW'(cand);
        gnt_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rwsgen_arb.sv
// rtl/rwsgen_arb.sv - multi-channel read/write strobe generator and register-bus arbiter
// Module rwsgen_arb
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   write/read            : per-channel level requests, held until waitrequest low
//   address/writedata     : packed per-channel address/data (channel i at [i*W +: W])
//   waitrequest           : per-channel, low for one cycle at completion
//   readdata              : last read result (all-ones after a read timeout)
//   readdatavalid/timeout : per-channel one-cycle completion qualifiers
//   upa/updo              : registered register-bus address/write data
//   updi/uprdy            : register-bus read data and one-cycle completion
//   upws/uprs             : one-cycle write/read strobes
//   upen_ws/upen_rs       : level enables from strobe through completion cycle
module rwsgen_arb
  import rwsgen_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int AW    = 16,
  parameter int DW    = 32,
  parameter int TOW   = 8,
  parameter int TOMAX = TOMAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    write,
  input  logic [NCH-1:0]    read,
  input  logic [NCH*AW-1:0] address,
  input  logic [NCH*DW-1:0] writedata,
  output logic [NCH-1:0]    waitrequest,
  output logic [DW-1:0]     readdata,
  output logic [NCH-1:0]    readdatavalid,
  output logic [NCH-1:0]    timeout,
  output logic [AW-1:0]     upa,
  output logic [DW-1:0]     updo,
  input  logic [DW-1:0]     updi,
  input  logic              uprdy,
  output logic              upws,
  output logic              uprs,
  output logic              upen_ws,
  output logic              upen_rs
);

  localparam int IW = idx_w(NCH);

  state_e          state_q;
  logic [IW-1:0]   grant_q;
  logic [IW-1:0]   last_grant_q;
  logic            is_wr_q;
  logic [TOW-1:0]  cnt_q;
  logic [AW-1:0]   upa_q;
  logic [DW-1:0]   updo_q;
  logic [DW-1:0]   rdata_q;
  logic            upws_q, uprs_q, upen_ws_q, upen_rs_q;
  logic [NCH-1:0]  wreq_q, rdv_q, to_q;

  logic [IW-1:0]   gnt_idx;
  logic            gnt_vld;
  logic [AW-1:0]   sel_addr_d;
  logic [DW-1:0]   sel_wdata_d;
  logic            sel_wr_d;
  logic [NCH-1:0]  done_oh_d;
  logic            cnt_hit_d;

  rr_arb #(
    .NCH (NCH),
    .IW  (IW)
  ) u_rr_arb (
    .req_i        (write | read),
    .last_grant_i (last_grant_q),
    .gnt_idx_o    (gnt_idx),
    .gnt_vld_o    (gnt_vld)
  );

  // Select the granted channel's request; write wins when both are high.
  always_comb begin
    sel_addr_d  = '0;
    sel_wdata_d = '0;
    sel_wr_d    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_addr_d  = address[i*AW +: AW];
        sel_wdata_d = writedata[i*DW +: DW];
        sel_wr_d    = write[i];
      end
    end
  end

  assign done_oh_d = NCH'(1) << grant_q;
  assign cnt_hit_d = (cnt_q == TOW'(TOMAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(NCH - 1);
      is_wr_q      <= 1'b0;
      cnt_q        <= '0;
      upa_q        <= '0;
      updo_q       <= '0;
      rdata_q      <= '0;
      upws_q       <= 1'b0;
      uprs_q       <= 1'b0;
      upen_ws_q    <= 1'b0;
      upen_rs_q    <= 1'b0;
      wreq_q       <= '1;
      rdv_q        <= '0;
      to_q         <= '0;
    end else begin
      // Strobes and completion qualifiers are single-cycle by default.
      upws_q <= 1'b0;
      uprs_q <= 1'b0;
      wreq_q <= '1;
      rdv_q  <= '0;
      to_q   <= '0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_vld) begin
            grant_q   <= gnt_idx;
            is_wr_q   <= sel_wr_d;
            upa_q     <= sel_addr_d;
            updo_q    <= sel_wdata_d;
            upws_q    <= sel_wr_d;
            uprs_q    <= !sel_wr_d;
            upen_ws_q <= sel_wr_d;
            upen_rs_q <= !sel_wr_d;
            cnt_q     <= '0;
            state_q   <= ST_STRB;
          end
        end
        // STRB and WAIT share completion handling; the counter is 0 in STRB
        // so a timeout there only happens when TOMAX is 0.
        ST_STRB, ST_WAIT: begin
          if (uprdy || cnt_hit_d) begin
            state_q   <= ST_DONE;
            upen_ws_q <= 1'b0;
            upen_rs_q <= 1'b0;
            wreq_q    <= ~done_oh_d;
            if (!is_wr_q) begin
              rdv_q   <= done_oh_d;
              rdata_q <= uprdy ? updi : '1;
            end
            if (!uprdy) begin
              to_q <= done_oh_d;
            end
          end else begin
            cnt_q   <= cnt_q + TOW'(1);
            state_q <= ST_WAIT;
          end
        end
        ST_DONE: begin
          last_grant_q <= grant_q;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign waitrequest   = wreq_q;
  assign readdata      = rdata_q;
  assign readdatavalid = rdv_q;
  assign timeout       = to_q;
  assign upa           = upa_q;
  assign updo          = updo_q;
  assign upws          = upws_q;
  assign uprs          = uprs_q;
  assign upen_ws       = upen_ws_q;
  assign upen_rs       = upen_rs_q;

endmodule

// File: tb/tb_rwsgen_arb.sv
// tb/tb_rwsgen_arb.sv - self-checking bench for rwsgen_arb
module tb_rwsgen_arb;

  localparam int NCH   = 2;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int TOW   = 8;
  localparam int TOMAX = 15;

  typedef struct {
    int          ch;
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] rdata;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    write, read, waitrequest, readdatavalid, timeout;
  logic [NCH*AW-1:0] address;
  logic [NCH*DW-1:0] writedata;
  logic [DW-1:0]     readdata, updo;
  logic [DW-1:0]     updi = '0;
  logic [AW-1:0]     upa;
  logic              uprdy = 1'b0;
  logic              upws, uprs, upen_ws, upen_rs;

  logic [NCH-1:0]    wr_en = '0, rd_en = '0;
  int                target[NCH] = '{0, 0};
  int                done_cnt[NCH] = '{0, 0};
  logic [AW-1:0]     addr_v[NCH];
  logic [DW-1:0]     wdata_v[NCH];

  txn_t sb[$];
  txn_t cur;
  int   cyc = 0;
  int   n_checks = 0, n_errors = 0;
  bit   in_txn = 0;
  bit   cont_mode = 0;
  int   strb_cyc = 0, prev_strb = -1, last_strobe_cyc = 0;
  int   rdy_cnt = -1, en_ok = 0, en_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      write[c] = wr_en[c] && (done_cnt[c] < target[c]);
      read[c]  = rd_en[c] && (done_cnt[c] < target[c]);
      address[c*AW +: AW]   = addr_v[c];
      writedata[c*DW +: DW] = wdata_v[c];
    end
  end

  rwsgen_arb #(
    .NCH(NCH), .AW(AW), .DW(DW), .TOW(TOW), .TOMAX(TOMAX)
  ) dut (
    .clk(clk), .rst(rst), .write(write), .read(read),
    .address(address), .writedata(writedata),
    .waitrequest(waitrequest), .readdata(readdata),
    .readdatavalid(readdatavalid), .timeout(timeout),
    .upa(upa), .updo(updo), .updi(updi), .uprdy(uprdy),
    .upws(upws), .uprs(uprs), .upen_ws(upen_ws), .upen_rs(upen_rs)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bus responder plus scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [NCH-1:0] oh;
    int             lat;
    uprdy = 1'b0;
    if (rst) begin
      in_txn  = 0;
      rdy_cnt = -1;
    end else begin
      if (upws || uprs) begin
        chk("strobe_excl", {63'd0, upws && uprs}, 64'd0);
        if (sb.size() == 0 || in_txn) begin
          chk("strobe_unexpected", {63'd0, upws}, {63'd0, uprs});
          chk("strobe_unexpected", 64'd1, 64'd0);
        end else begin
          cur = sb[0];
          chk("strobe_type", {62'd0, upws, uprs}, cur.wr ? 64'd2 : 64'd1);
          chk("strobe_upa", {48'd0, upa}, {48'd0, cur.addr});
          if (cur.wr) chk("strobe_updo", {32'd0, updo}, {32'd0, cur.wdata});
          if (cont_mode && prev_strb >= 0) chk("strobe_gap", 64'(cyc - prev_strb), 64'd3);
          prev_strb       = cyc;
          last_strobe_cyc = cyc;
          strb_cyc        = cyc;
          in_txn          = 1;
          rdy_cnt         = cur.dly;
          en_ok           = 0;
          en_bad          = 0;
        end
      end
      if (in_txn) begin
        en_ok  += int'(cur.wr ? upen_ws : upen_rs);
        en_bad += int'(cur.wr ? upen_rs : upen_ws);
        if (rdy_cnt == 0) begin
          uprdy = 1'b1;
          updi  = cur.rdata;
        end
        if (rdy_cnt >= 0) rdy_cnt--;
      end
      if (waitrequest != '1) begin
        if (!in_txn) begin
          chk("completion_unexpected", {62'd0, waitrequest}, {62'd0, {NCH{1'b1}}});
        end else begin
          oh  = NCH'(1) << cur.ch;
          lat = (cur.dly < 0) ? TOMAX + 1 : cur.dly + 1;
          chk("done_waitreq", {62'd0, waitrequest}, {62'd0, ~oh});
          chk("done_rdv", {62'd0, readdatavalid}, cur.wr ? 64'd0 : {62'd0, oh});
          chk("done_timeout", {62'd0, timeout}, (cur.dly < 0) ? {62'd0, oh} : 64'd0);
          if (!cur.wr) chk("done_readdata", {32'd0, readdata},
                           (cur.dly < 0) ? 64'hFFFF_FFFF : {32'd0, cur.rdata});
          chk("done_latency", 64'(cyc - strb_cyc), 64'(lat));
          chk("upen_cycles", 64'(en_ok), 64'(lat));
          chk("upen_wrong", 64'(en_bad), 64'd0);
          done_cnt[cur.ch]++;
          void'(sb.pop_front());
          in_txn = 0;
        end
      end else if (|readdatavalid || |timeout) begin
        chk("stray_pulse", {60'd0, readdatavalid, timeout}, 64'd0);
      end
    end
  end

  task automatic check_reset(input string pfx);
    chk({pfx, "_waitreq"}, {62'd0, waitrequest}, {62'd0, {NCH{1'b1}}});
    chk({pfx, "_strobes"}, {60'd0, upws, uprs, upen_ws, upen_rs}, 64'd0);
    chk({pfx, "_pulses"}, {60'd0, readdatavalid, timeout}, 64'd0);
    chk({pfx, "_upa"}, {48'd0, upa}, 64'd0);
    chk({pfx, "_updo"}, {32'd0, updo}, 64'd0);
    chk({pfx, "_readdata"}, {32'd0, readdata}, 64'd0);
  endtask

  task automatic one(input int ch, input bit wr, input bit rd, input logic [15:0] a,
                     input logic [31:0] d, input int dly, input logic [31:0] rdat);
    txn_t t;
    t.ch = ch; t.wr = wr; t.addr = a; t.wdata = d; t.dly = dly; t.rdata = rdat;
    sb.push_back(t);
    addr_v[ch]  = a;
    wdata_v[ch] = d;
    wr_en[ch]   = wr;
    rd_en[ch]   = rd;
    target[ch]  = done_cnt[ch] + 1;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while ((sb.size() != 0 || in_txn) && n < bound) begin
      @(posedge clk); #2;
      n++;
    end
    chk(tag, {63'd0, sb.size() == 0 && !in_txn}, 64'd1);
    sb.delete();
    wr_en = '0;
    rd_en = '0;
    for (int c = 0; c < NCH; c++) target[c] = done_cnt[c];
    @(posedge clk); #2;
  endtask

  initial begin
    int  req_cyc;
    int  rel_cyc;
    bit  got;
    for (int c = 0; c < NCH; c++) begin
      addr_v[c]  = '0;
      wdata_v[c] = '0;
    end
    repeat (3) @(posedge clk);
    #2;
    check_reset("reset");
    rst = 1'b0;
    @(posedge clk); #2;

    // single write ch0, uprdy three cycles after the strobe
    req_cyc = cyc;
    one(0, 1, 0, 16'h0010, 32'hA5A5_5A5A, 3, 32'h0);
    wait_idle("wr_ch0_done", 40);
    chk("wr_ch0_req2strb", 64'(last_strobe_cyc - req_cyc), 64'd1);

    // read ch1, uprdy in the strobe cycle
    req_cyc = cyc;
    one(1, 0, 1, 16'h0200, 32'h0, 0, 32'h1234_5678);
    wait_idle("rd_ch1_done", 40);
    chk("rd_ch1_req2strb", 64'(last_strobe_cyc - req_cyc), 64'd1);

    // ch0 writes and ch1 reads competing continuously
    begin
      txn_t t;
      prev_strb = -1;
      cont_mode = 1;
      t.ch = 0; t.wr = 1; t.addr = 16'h0100; t.wdata = 32'h1111_2222; t.dly = 0; t.rdata = 0;
      sb.push_back(t);
      t.ch = 1; t.wr = 0; t.addr = 16'h0104; t.wdata = 32'h0; t.rdata = 32'h3333_4444;
      sb.push_back(t);
      t.ch = 0; t.wr = 1; t.addr = 16'h0100; t.wdata = 32'h1111_2222; t.rdata = 0;
      sb.push_back(t);
      t.ch = 1; t.wr = 0; t.addr = 16'h0104; t.wdata = 32'h0; t.rdata = 32'h5555_6666;
      sb.push_back(t);
      addr_v[0] = 16'h0100; wdata_v[0] = 32'h1111_2222;
      addr_v[1] = 16'h0104; wdata_v[1] = 32'h0;
      wr_en[0] = 1'b1; rd_en[1] = 1'b1;
      target[0] = done_cnt[0] + 2;
      target[1] = done_cnt[1] + 2;
      wait_idle("rr_done", 80);
      cont_mode = 0;
    end

    // read ch0 with no uprdy: timeout after TOMAX+1 wait cycles
    req_cyc = cyc;
    one(0, 0, 1, 16'h0300, 32'h0, -1, 32'h0);
    wait_idle("to_ch0_done", 60);
    chk("to_ch0_req2strb", 64'(last_strobe_cyc - req_cyc), 64'd1);

    // reset while waiting for uprdy
    one(0, 0, 1, 16'h0400, 32'h0, -1, 32'h0);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #2;
      if (in_txn) got = 1;
    end
    chk("rst_strobe_seen", {63'd0, got}, 64'd1);
    repeat (2) begin
      @(posedge clk); #2;
    end
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #2;
    check_reset("midrst");
    rel_cyc = cyc;
    begin
      txn_t t;
      t.ch = 0; t.wr = 0; t.addr = 16'h0400; t.wdata = 32'h0; t.dly = 1; t.rdata = 32'hCAFE_F00D;
      sb.push_back(t);
    end
    rst = 1'b0;
    wait_idle("rst_redo_done", 40);
    chk("rst_restrobe", 64'(last_strobe_cyc - rel_cyc), 64'd1);

    // read and write both high on ch0: write only
    one(0, 1, 1, 16'h0500, 32'hDEAD_BEEF, 1, 32'h0);
    wait_idle("rw_ch0_done", 40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
